// File: rtl/core_pkg.sv
// core_pkg: shared constants for the RV32I multi-cycle control unit.
//   - RV32I opcode constants (plus the custom rsqr coprocessor opcode)
//   - FSM state encoding (IDLE=0 .. TRAP=7)
//   - ALU operation encoding and a funct3 -> ALU op helper
//   - pc_sel / wb_sel encodings
package core_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_COP    = 7'b0001011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_COPW   = 3'd5;
    localparam logic [2:0] S_WB     = 3'd6;
    localparam logic [2:0] S_TRAP   = 3'd7;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_REL   = 2'b01;
    localparam logic [1:0] PC_JALR  = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_COP  = 2'b11;

    // funct3 -> ALU op. 'alt' selects the funct7[5] variant (SUB / SRA);
    // it only matters for funct3 000 and 101.
    function automatic alu_op_e f3_alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f3_alu_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  f3_alu_op = ALU_SLL;
            3'b010:  f3_alu_op = ALU_SLT;
            3'b011:  f3_alu_op = ALU_SLTU;
            3'b100:  f3_alu_op = ALU_XOR;
            3'b101:  f3_alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  f3_alu_op = ALU_OR;
            default: f3_alu_op = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational instruction classifier.
//   opcode, f3, f7 : decoder fields of the current instruction
//   alu_op         : ALU operation for the EXEC cycle
//   legal          : 1 when the encoding is a supported instruction
module alu_op_decode
    import core_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    output alu_op_e    alu_op,
    output logic       legal
);

    logic f7_std;
    assign f7_std = (f7 == 7'b0000000) || (f7 == 7'b0100000);

    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b0;
        case (opcode)
            OP_R: begin
                alu_op = f3_alu_op(f3, f7[5]);
                legal  = f7_std;
            end
            OP_I: begin
                // Immediate ALU ops have no SUBI; f7[5] only picks SRAI.
                alu_op = f3_alu_op(f3, f7[5] && (f3 == 3'b101));
                case (f3)
                    3'b001:  legal = (f7 == 7'b0000000);
                    3'b101:  legal = f7_std;
                    default: legal = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                alu_op = ALU_SUB;
                legal  = 1'b1;
            end
            OP_LUI: begin
                alu_op = ALU_PASS_B;
                legal  = 1'b1;
            end
            OP_LOAD, OP_STORE, OP_JALR, OP_JAL, OP_AUIPC, OP_COP: begin
                alu_op = ALU_ADD;
                legal  = 1'b1;
            end
            default: begin
                alu_op = ALU_ADD;
                legal  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm: multi-cycle control FSM of the RV32I core.
//   Inputs : clk, rst_n (async, active low), opcode/f3/f7 from the IR,
//            imem_ready, dmem_ready, cop_done, branch_taken
//   Outputs: imem_req, ir_we, dmem_req, dmem_we, cop_start, pc_we, pc_sel,
//            alu_src_a, alu_src_b, alu_op, rf_we, wb_sel, trap,
//            state (debug view of the FSM register)
//
// Handshakes: a request (imem_req / dmem_req) is held high for every cycle
// the FSM sits in FETCH / MEM; the transfer completes in the first cycle the
// matching ready is high, including the entry cycle. cop_start is a single
// cycle pulse on the EXEC -> COPW transition and cop_done is only sampled in
// COPW. Readies and done seen in any other state are ignored.
module core_ctrl_fsm
    import core_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    input  logic       cop_done,
    input  logic       branch_taken,
    output logic       imem_req,
    output logic       ir_we,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       cop_start,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic [3:0] alu_op,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       trap,
    output logic [2:0] state
);

    logic [2:0] state_q;
    logic [2:0] state_d;
    alu_op_e    dec_op;
    logic       dec_legal;

    alu_op_decode u_alu_op_decode (
        .opcode (opcode),
        .f3     (f3),
        .f7     (f7),
        .alu_op (dec_op),
        .legal  (dec_legal)
    );

    logic is_r, is_branch, is_load, is_store, is_cop, is_jal, is_jalr, is_auipc;
    assign is_r      = (opcode == OP_R);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_cop    = (opcode == OP_COP);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_auipc  = (opcode == OP_AUIPC);

    // Reset forces IDLE immediately, and IDLE decodes to all-zero outputs,
    // so an in-flight request drops in the same cycle reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        cop_start = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        alu_op    = ALU_ADD;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        trap      = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            // DECODE exists so the decoder's registered immediate settles.
            S_DECODE: state_d = dec_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                alu_op    = dec_op;
                alu_src_a = is_auipc;
                alu_src_b = !(is_r || is_branch);
                if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (is_cop) begin
                    cop_start = 1'b1;
                    state_d   = S_COPW;
                end else if (is_branch) begin
                    pc_we   = 1'b1;
                    pc_sel  = branch_taken ? PC_REL : PC_PLUS4;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ready) begin
                    if (is_store) begin
                        pc_we   = 1'b1;
                        pc_sel  = PC_PLUS4;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_COPW: begin
                if (cop_done) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                pc_sel  = is_jal ? PC_REL : (is_jalr ? PC_JALR : PC_PLUS4);
                wb_sel  = (is_jal || is_jalr) ? WB_PC4 :
                          is_load ? WB_LOAD :
                          is_cop  ? WB_COP  : WB_ALU;
                state_d = S_FETCH;
            end
            default: trap = 1'b1;  // S_TRAP: absorbing until reset
        endcase
    end

endmodule
